// File: rtl/gba_eeprom_host.sv
// gba_eeprom_host: serial initiator for the GBA cartridge EEPROM 1-bit protocol.
// Walks one 64-bit block read or write through the EEPROM responder beat by beat.
// Optional build macro GBA_EEPROM_HOST_STATS_EN adds saturating completion counters
// (stat_rd, stat_wr, stat_to); without it those ports and their logic are absent.
module gba_eeprom_host #(
  parameter int GAP      = 1,
  parameter int POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        model,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        ee_cs,
  output logic        ee_valid,
  output logic        ee_write,
  output logic        ee_din,
  input  logic        ee_ready,
  input  logic        ee_dout
`ifdef GBA_EEPROM_HOST_STATS_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [7:0]  stat_to
`endif
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CMD   = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_WDATA = 4'd3;
  localparam logic [3:0] S_STOP  = 4'd4;
  localparam logic [3:0] S_RHEAD = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_POLL  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);

  logic [3:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          samp_q, samp_d;   // first gap cycle after a read beat
  logic          sbit_q, sbit_d;   // held copy of the last sampled bit
  logic          model_q, model_d;
  logic          write_q, write_d;
  logic          to_q, to_d;
  logic [13:0]   addr_q, addr_d;   // MSB-aligned so [13] is always the next bit
  logic [63:0]   wdat_q, wdat_d;
  logic [63:0]   rsr_q, rsr_d;     // read shift register, published at completion
  logic [63:0]   rdata_q, rdata_d;
  logic          live_q;           // keeps req_ready low while reset is asserted

  logic          cur_bit;
  logic [6:0]    last_addr;
  logic          wr_state;

  // Beat-stream outputs are pure functions of registered state, so they hold while stalled.
  always_comb begin
    wr_state = (state_q == S_CMD) || (state_q == S_ADDR) ||
               (state_q == S_WDATA) || (state_q == S_STOP);
    ee_din = 1'b0;
    case (state_q)
      S_CMD:   ee_din = (cnt_q == 7'd0) ? 1'b1 : ~write_q;
      S_ADDR:  ee_din = addr_q[13];
      S_WDATA: ee_din = wdat_q[63];
      default: ee_din = 1'b0;
    endcase
  end

  assign ee_write    = wr_state;
  assign ee_valid    = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign ee_cs       = busy;
  assign req_ready   = live_q && (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_timeout = rsp_valid && to_q;
  assign rsp_rdata   = rdata_q;

  // Next-state: beat handshake, gap countdown, then per-state sequencing at gap end.
  always_comb begin
    state_d = state_q;  valid_d = valid_q;  gap_d   = gap_q;   cnt_d   = cnt_q;
    poll_d  = poll_q;   samp_d  = samp_q;   sbit_d  = sbit_q;  model_d = model_q;
    write_d = write_q;  to_d    = to_q;     addr_d  = addr_q;  wdat_d  = wdat_q;
    rdata_d = rdata_q;
    // With GAP=1 the sample cycle is also the decision cycle, so use ee_dout directly.
    cur_bit   = samp_q ? ee_dout : sbit_q;
    rsr_d     = (samp_q && state_q == S_RDATA) ? {rsr_q[62:0], ee_dout} : rsr_q;
    last_addr = model_q ? 7'd13 : 7'd5;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_CMD;
          valid_d = 1'b1;
          cnt_d   = 7'd0;
          poll_d  = '0;
          to_d    = 1'b0;
          samp_d  = 1'b0;
          model_d = model;
          write_d = req_write;
          addr_d  = model ? req_addr : {req_addr[5:0], 8'h00};
          wdat_d  = req_wdata;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (valid_q) begin
          if (ee_ready) begin
            valid_d = 1'b0;
            gap_d   = GW'(GAP - 1);
            samp_d  = ~wr_state;
          end
        end else begin
          if (samp_q) begin
            sbit_d = ee_dout;
            samp_d = 1'b0;
          end
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + 7'd1;
            case (state_q)
              S_CMD: if (cnt_q == 7'd1) begin state_d = S_ADDR; cnt_d = 7'd0; end
              S_ADDR: begin
                addr_d = {addr_q[12:0], 1'b0};
                if (cnt_q == last_addr) begin
                  state_d = write_q ? S_WDATA : S_STOP;
                  cnt_d   = 7'd0;
                end
              end
              S_WDATA: begin
                wdat_d = {wdat_q[62:0], 1'b0};
                if (cnt_q == 7'd63) begin state_d = S_STOP; cnt_d = 7'd0; end
              end
              S_STOP: begin
                state_d = write_q ? S_POLL : S_RHEAD;
                cnt_d   = 7'd0;
              end
              S_RHEAD: if (cnt_q == 7'd3) begin state_d = S_RDATA; cnt_d = 7'd0; end
              S_RDATA: begin
                if (cnt_q == 7'd63) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  rdata_d = rsr_d;
                end
              end
              S_POLL: begin
                if (cur_bit) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                end else if (poll_q == PW'(POLL_MAX - 1)) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  to_d    = 1'b1;
                end else begin
                  poll_d = poll_q + PW'(1);
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // State registers; reset abandons any transfer without a completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  valid_q <= 1'b0;  gap_q   <= '0;     cnt_q   <= 7'd0;
      poll_q  <= '0;      samp_q  <= 1'b0;  sbit_q  <= 1'b0;   model_q <= 1'b0;
      write_q <= 1'b0;    to_q    <= 1'b0;  addr_q  <= 14'd0;  wdat_q  <= 64'd0;
      rsr_q   <= 64'd0;   rdata_q <= 64'd0; live_q  <= 1'b0;
    end else begin
      state_q <= state_d;  valid_q <= valid_d;  gap_q   <= gap_d;   cnt_q   <= cnt_d;
      poll_q  <= poll_d;   samp_q  <= samp_d;   sbit_q  <= sbit_d;  model_q <= model_d;
      write_q <= write_d;  to_q    <= to_d;     addr_q  <= addr_d;  wdat_q  <= wdat_d;
      rsr_q   <= rsr_d;    rdata_q <= rdata_d;  live_q  <= 1'b1;
    end
  end

`ifdef GBA_EEPROM_HOST_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q;
  logic [7:0]  stat_to_q;

  // Saturating completion counters, bumped in the completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q <= 16'd0;
      stat_wr_q <= 16'd0;
      stat_to_q <= 8'd0;
    end else if (state_q == S_DONE) begin
      if (write_q && stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
      if (!write_q && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      if (to_q && stat_to_q != 8'hFF) stat_to_q <= stat_to_q + 8'd1;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
  assign stat_to = stat_to_q;
`endif

endmodule

// File: doc/gba_eeprom_host.md
Name: gba_eeprom_host

Overview:
- Serial initiator for the GBA cartridge EEPROM 1-bit protocol. It generates, bit by bit, the beat stream that the GBA DMA3 would otherwise drive.
- Lets the RV side or a test harness read or write one 64-bit block through the existing EEPROM responder without a CPU, for save import/export and self-test.
- Sits between a simple request/response port and the responder's cs/valid/write/din/dout/ready pins.

Parameters:
- GAP, 1: idle cycles (ee_valid low) after each accepted beat. Minimum 1, because the responder's dout is registered.
- POLL_MAX, 1023: maximum ready-poll reads after a write before a timeout is declared.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- model  in  1  0: 6-bit address (4 Kbit), 1: 14-bit address (64 Kbit)
- req_valid  in  1  request strobe
- req_ready  out  1  high in IDLE only; request accepted when req_valid&req_ready
- req_write  in  1  1: write block, 0: read block
- req_addr  in  14  block address; only [5:0] used when model=0
- req_wdata  in  64  write data, bit 63 sent first
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  64  read data, held until the next read completes
- rsp_timeout  out  1  qualifies rsp_valid: write ready-poll exceeded POLL_MAX
- busy  out  1  high from acceptance through the rsp_valid cycle
- ee_cs  out  1  asserted whenever busy
- ee_valid  out  1  beat strobe toward the responder
- ee_write  out  1  1: host-to-EEPROM bit, 0: read beat
- ee_din  out  1  bit driven on write beats, 0 on read beats
- ee_ready  in  1  beat accepted when ee_valid&ee_ready
- ee_dout  in  1  EEPROM output bit

Behaviour:
- Reset values: req_ready=0 while reset is asserted, then 1 (IDLE). All other outputs 0; rsp_rdata=0.
- Async reset mid-transfer: immediate return to IDLE, ee_valid low, no rsp_valid emitted.
- Beat rule:
  - ee_valid, ee_write and ee_din are held stable until ee_ready is sampled high.
  - Then ee_valid drops for GAP cycles.
  - Read-beat data is sampled from ee_dout in the first gap cycle, one cycle after acceptance.
- Latched at acceptance: model, req_write, req_addr, req_wdata, into shift registers. N = model ? 14 : 6. Later changes to model are ignored.
- FSM:
  - IDLE: on accept, go to CMD.
  - CMD: 2 write beats, "1" then (req_write ? "0" : "1").
  - ADDR: N write beats, address MSB first. Then WDATA if writing, otherwise STOP.
  - WDATA: 64 write beats, req_wdata[63] first.
  - STOP: 1 write beat "0". Then POLL if writing, otherwise RHEAD.
  - RHEAD: 4 read beats, sampled values discarded.
  - RDATA: 64 read beats. Each sample is shifted into rsp_rdata LSB-in, so the first bit read lands in [63].
  - POLL: read beats until a sample is 1, or until POLL_MAX reads without a 1, which sets rsp_timeout. The first poll read counts as 1.
  - DONE: one cycle with rsp_valid=1 and busy=1, then IDLE.
- Beat totals:
  - Read: 3+N write beats, then 68 read beats.
  - Write: 67+N write beats, then 1 to POLL_MAX poll reads.
- Latency with ee_ready tied high: each beat takes 1+GAP cycles. A 6-bit read with GAP=1 takes 2*(9+68)=154 cycles from acceptance to DONE.
- The 14-bit ADDR field is only counted from the latched model. Upper req_addr bits are ignored when model=0.
- A request during busy is not accepted (req_ready=0). A request in the DONE cycle is not accepted; it is accepted on the next cycle.
- ee_ready held low: the FSM waits indefinitely. There is no timeout except in POLL.
- rsp_timeout is 0 on reads and on successful writes.

Optional Feature:
- GBA_EEPROM_HOST_STATS_EN defined: adds outputs stat_rd (16 bits), stat_wr (16 bits) and stat_to (8 bits).
  - stat_rd increments on each completed read and stat_wr on each completed write. stat_to increments on each timeout; a timed-out write also counts in stat_wr.
  - All three saturate at all-ones and are cleared by rst_n.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Read, model=0, addr=0x2A, responder preloaded with 0x0123456789ABCDEF at block 0x2A, GAP=1, ee_ready=1 -> write bits 1,1,101010,0; 68 reads; rsp_valid at cycle 154; rsp_rdata=0x0123456789ABCDEF; rsp_timeout=0.
- Write, model=1, addr=0x1FFF, data 0xDEADBEEFCAFEF00D, then read back -> 2+14+64+1=81 write beats; poll ends on the first 1; read returns 0xDEADBEEFCAFEF00D.
- Poll timeout: after a write, model ee_dout stuck at 0, POLL_MAX=8 -> exactly 8 poll reads, rsp_valid with rsp_timeout=1, then req_ready=1.
- ee_ready held low for 5 cycles on the 3rd beat -> ee_valid, ee_write and ee_din stable throughout; beat count and data unchanged; total latency +5.
- rst_n pulsed low during RDATA beat 20 -> ee_valid=0 and busy=0 asynchronously; no rsp_valid; next request completes normally.
- req_valid held high through a transfer with a second request waiting -> accepted only in the cycle after rsp_valid; with STATS_EN, stat_rd=2 after both reads.
